// File: rtl/poly_sub_reduce_pkg.sv
// poly_sub_reduce_pkg
// Shared Kyber constants, decode thresholds and the datapath FSM state
// encoding. The encapsulation adder uses the same debug encoding.
package poly_sub_reduce_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_R_WIDTH = 12;
  localparam int KYBER_Q       = 3329;

  // Compress_1 decision window: a coefficient decodes to 1 inside [833, 2496]
  localparam logic [KYBER_R_WIDTH-1:0] KYBER_Q_QUARTER_HI = 12'd833;
  localparam logic [KYBER_R_WIDTH-1:0] KYBER_Q_3QUARTER   = 12'd2496;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPUTE = 3'd1,
    ST_DONE    = 3'd2
  } state_t;

endpackage

// File: rtl/poly_sub_reduce_mod_sub_lane.sv
// mod_sub_lane
// Combinational single-coefficient modular subtract w = (a - b) mod q for
// operands already in [0, q).
// Optional macro POLY_SUB_DECODE_EN adds the Compress_1 message bit.
// Ports:
//   a   in  12  minuend coefficient
//   b   in  12  subtrahend coefficient
//   w   out 12  (a - b) mod q
//   msg out 1   decoded message bit (only with POLY_SUB_DECODE_EN)
module mod_sub_lane
  import poly_sub_reduce_pkg::*;
(
  input  logic [KYBER_R_WIDTH-1:0] a,
  input  logic [KYBER_R_WIDTH-1:0] b,
  output logic [KYBER_R_WIDTH-1:0] w
`ifdef POLY_SUB_DECODE_EN
  ,
  output logic                     msg
`endif
);

  // One conditional add of q brings the 13-bit signed difference back into
  // range because both operands are below q.
  function automatic logic [KYBER_R_WIDTH-1:0] mod_sub(
    input logic [KYBER_R_WIDTH-1:0] x,
    input logic [KYBER_R_WIDTH-1:0] y
  );
    logic signed [KYBER_R_WIDTH:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d[KYBER_R_WIDTH])
      d = d + $signed((KYBER_R_WIDTH+1)'(KYBER_Q));
    return d[KYBER_R_WIDTH-1:0];
  endfunction

  assign w = mod_sub(a, b);

`ifdef POLY_SUB_DECODE_EN
  function automatic logic decode_bit(input logic [KYBER_R_WIDTH-1:0] x);
    return (x >= KYBER_Q_QUARTER_HI) && (x <= KYBER_Q_3QUARTER);
  endfunction

  assign msg = decode_bit(w);
`endif

endmodule

// File: rtl/poly_sub_reduce.sv
// poly_sub_reduce
// Decapsulation-side w = v - s^T*u mod q over one Kyber polynomial,
// LANES coefficients per COMPUTE cycle, result fully reduced to [0, q).
// Optional macro POLY_SUB_DECODE_EN adds the decoded message output msg.
// Ports:
//   clk         in  1      rising-edge clock
//   rst         in  1      synchronous active-high reset
//   enable      in  1      start request, sampled in IDLE
//   v           in  N*12   minuend polynomial, coeff i at [12i+11:12i]
//   su          in  N*12   subtrahend polynomial, same packing
//   w           out N*12   result polynomial
//   valid       out 1      high while the result is held in DONE
//   debug_state out 3      FSM state (IDLE=0, COMPUTE=1, DONE=2)
//   msg         out N      decoded message (only with POLY_SUB_DECODE_EN)
module poly_sub_reduce
  import poly_sub_reduce_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   v,
  input  logic [KYBER_N*KYBER_R_WIDTH-1:0]   su,
  output logic [KYBER_N*KYBER_R_WIDTH-1:0]   w,
  output logic                               valid,
  output logic [2:0]                         debug_state
`ifdef POLY_SUB_DECODE_EN
  ,
  output logic [KYBER_N-1:0]                 msg
`endif
);

  localparam int GROUPS = KYBER_N / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int RW     = KYBER_R_WIDTH;

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic [KYBER_N*RW-1:0]        v_buf, su_buf;
  logic                         last_group;

  logic [RW-1:0]                lane_v  [LANES];
  logic [RW-1:0]                lane_su [LANES];
  logic [RW-1:0]                lane_w  [LANES];
`ifdef POLY_SUB_DECODE_EN
  logic                         lane_msg [LANES];
`endif

  assign last_group  = (cnt == CNT_W'(GROUPS - 1));
  assign valid       = (state == ST_DONE);
  assign debug_state = state;

  // Lane datapath: select the current group from the latched buffers
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_v[l]  = v_buf [(int'(cnt)*LANES + l)*RW +: RW];
    assign lane_su[l] = su_buf[(int'(cnt)*LANES + l)*RW +: RW];

    mod_sub_lane u_lane (
      .a   (lane_v[l]),
      .b   (lane_su[l]),
      .w   (lane_w[l])
`ifdef POLY_SUB_DECODE_EN
      ,
      .msg (lane_msg[l])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable)     state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (last_group) state_nxt = ST_DONE;
      ST_DONE:    if (!enable)    state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Result register: one lane group written per COMPUTE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      v_buf  <= '0;
      su_buf <= '0;
      w      <= '0;
      cnt    <= '0;
`ifdef POLY_SUB_DECODE_EN
      msg    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            v_buf  <= v;
            su_buf <= su;
            cnt    <= '0;
          end
        end
        ST_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            w[(int'(cnt)*LANES + l)*RW +: RW] <= lane_w[l];
`ifdef POLY_SUB_DECODE_EN
            msg[int'(cnt)*LANES + l] <= lane_msg[l];
`endif
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sub_reduce.sv
module tb_poly_sub_reduce;
  localparam int N = 256;
  localparam int Q = 3329;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [N*12-1:0]  v, su;
  logic [N*12-1:0]  w;
  logic             valid;
  logic [2:0]       debug_state;
`ifdef POLY_SUB_DECODE_EN
  logic [N-1:0]     msg;
`endif

  int total = 0;
  int bad   = 0;

  int mv [N];
  int ms [N];
  int exp_w [N];

  poly_sub_reduce #(.LANES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .v           (v),
    .su          (su),
    .w           (w),
    .valid       (valid),
    .debug_state (debug_state)
`ifdef POLY_SUB_DECODE_EN
    ,
    .msg         (msg)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular arithmetic on integers
  function automatic int ref_sub(int a, int b);
    return ((a - b) % Q + Q) % Q;
  endfunction

  // round(2w/q) mod 2, using integer rounding of 2w/q
  function automatic int ref_decode(int x);
    return ((4 * x + Q) / (2 * Q)) % 2;
  endfunction

  task automatic load_inputs();
    for (int i = 0; i < N; i++) begin
      v[i*12 +: 12]  = 12'(mv[i]);
      su[i*12 +: 12] = 12'(ms[i]);
      exp_w[i]       = ref_sub(mv[i], ms[i]);
    end
  endtask

  function automatic int first_bad_w();
    for (int i = 0; i < N; i++)
      if (int'(w[i*12 +: 12]) != exp_w[i]) return i;
    return -1;
  endfunction

`ifdef POLY_SUB_DECODE_EN
  function automatic int first_bad_msg();
    for (int i = 0; i < N; i++)
      if (int'(msg[i]) != ref_decode(exp_w[i])) return i;
    return -1;
  endfunction
`endif

  // Raise enable (E0), then wait for valid; returns edges after E0, -1 on timeout
  task automatic start_and_wait(output int edges);
    enable = 1'b1;
    step();
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (valid) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic finish_run();
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; v = '1; su = '0;
    step(); step();
    total++;
    if (w !== '0) begin bad++; $display("FAIL reset_w: got nonzero w, want 0"); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++;
    if (debug_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", debug_state); end
`ifdef POLY_SUB_DECODE_EN
    total++;
    if (msg !== '0) begin bad++; $display("FAIL reset_msg: got nonzero msg, want 0"); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_const();
    int edges, idx;
    for (int i = 0; i < N; i++) begin mv[i] = 5; ms[i] = 3; end
    load_inputs();
    enable = 1'b1;
    step();
    total++;
    if (debug_state !== 3'd1) begin bad++; $display("FAIL const_compute_state: got %0d want 1", debug_state); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL const_valid_early: got %b want 0", valid); end
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (valid) begin edges = n; break; end
    end
    total++;
    if (edges != 16) begin bad++; $display("FAIL const_latency: got %0d edges after E0 want 16", edges); end
    total++;
    if (debug_state !== 3'd2) begin bad++; $display("FAIL const_done_state: got %0d want 2", debug_state); end
    idx = first_bad_w();
    total++;
    if (idx != -1) begin bad++; $display("FAIL const_w: coeff %0d got %0d want %0d", idx, w[idx*12 +: 12], exp_w[idx]); end
    step();
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL const_hold_valid: got %b want 1", valid); end
    finish_run();
    total++;
    if (valid !== 1'b0 || debug_state !== 3'd0) begin
      bad++; $display("FAIL const_leave_done: valid %b state %0d want 0 0", valid, debug_state);
    end
    idx = first_bad_w();
    total++;
    if (idx != -1) begin bad++; $display("FAIL const_w_retained: coeff %0d got %0d want %0d", idx, w[idx*12 +: 12], exp_w[idx]); end
  endtask

  task automatic test_boundary();
    int edges, idx;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = (pass == 0) ? 0 : 3328;
        ms[i] = (pass == 0) ? 1 : 3328;
      end
      load_inputs();
      start_and_wait(edges);
      total++;
      if (edges != 16) begin bad++; $display("FAIL boundary_latency_%0d: got %0d want 16", pass, edges); end
      idx = first_bad_w();
      total++;
      if (idx != -1) begin bad++; $display("FAIL boundary_w_%0d: coeff %0d got %0d want %0d", pass, idx, w[idx*12 +: 12], exp_w[idx]); end
      finish_run();
    end
  endtask

  task automatic test_mixed();
    int edges, idx;
    logic [191:0] g_exp;
    for (int i = 0; i < N; i++) begin mv[i] = i % Q; ms[i] = (3 * i) % Q; end
    load_inputs();
    start_and_wait(edges);
    total++;
    if (edges != 16) begin bad++; $display("FAIL mixed_latency: got %0d want 16", edges); end
    idx = first_bad_w();
    total++;
    if (idx != -1) begin bad++; $display("FAIL mixed_w: coeff %0d got %0d want %0d", idx, w[idx*12 +: 12], exp_w[idx]); end
    for (int j = 0; j < 16; j++) g_exp[j*12 +: 12] = 12'(exp_w[j]);
    total++;
    if (w[0 +: 192] !== g_exp) begin bad++; $display("FAIL mixed_group0: got %h want %h", w[0 +: 192], g_exp); end
    for (int j = 0; j < 16; j++) g_exp[j*12 +: 12] = 12'(exp_w[240 + j]);
    total++;
    if (w[240*12 +: 192] !== g_exp) begin bad++; $display("FAIL mixed_group15: got %h want %h", w[240*12 +: 192], g_exp); end
`ifdef POLY_SUB_DECODE_EN
    idx = first_bad_msg();
    total++;
    if (idx != -1) begin bad++; $display("FAIL mixed_msg: bit %0d got %b", idx, msg[idx]); end
`endif
    finish_run();
  endtask

  task automatic test_random();
    int edges, idx;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = int'($urandom_range(0, Q - 1));
        ms[i] = int'($urandom_range(0, Q - 1));
      end
      load_inputs();
      start_and_wait(edges);
      total++;
      if (edges != 16) begin bad++; $display("FAIL random_latency_%0d: got %0d want 16", r, edges); end
      idx = first_bad_w();
      total++;
      if (idx != -1) begin bad++; $display("FAIL random_w_%0d: coeff %0d got %0d want %0d", r, idx, w[idx*12 +: 12], exp_w[idx]); end
`ifdef POLY_SUB_DECODE_EN
      idx = first_bad_msg();
      total++;
      if (idx != -1) begin bad++; $display("FAIL random_msg_%0d: bit %0d got %b", r, idx, msg[idx]); end
`endif
      finish_run();
    end
  endtask

  task automatic test_reset_abort();
    int edges, idx;
    for (int i = 0; i < N; i++) begin mv[i] = 100 + i; ms[i] = 7; end
    load_inputs();
    enable = 1'b1;
    step();                                  // E0
    for (int n = 1; n <= 7; n++) step();     // E1..E7
    rst = 1'b1;
    step();                                  // E8 with reset
    total++;
    if (w !== '0 || valid !== 1'b0 || debug_state !== 3'd0) begin
      bad++; $display("FAIL abort_reset: valid %b state %0d w_nonzero %b want 0 0 0", valid, debug_state, |w);
    end
    rst = 1'b0; enable = 1'b0;
    step();
    for (int i = 0; i < N; i++) begin mv[i] = 5; ms[i] = 3; end
    load_inputs();
    start_and_wait(edges);
    total++;
    if (edges != 16) begin bad++; $display("FAIL abort_rerun_latency: got %0d want 16", edges); end
    idx = first_bad_w();
    total++;
    if (idx != -1) begin bad++; $display("FAIL abort_rerun_w: coeff %0d got %0d want %0d", idx, w[idx*12 +: 12], exp_w[idx]); end
    finish_run();
  endtask

  task automatic test_enable_drop();
    int edges, idx;
    for (int i = 0; i < N; i++) begin
      mv[i] = int'($urandom_range(0, Q - 1));
      ms[i] = int'($urandom_range(0, Q - 1));
    end
    load_inputs();
    enable = 1'b1;
    step();                                  // E0 latches inputs
    step(); step();                          // E1, E2
    v = ~v; su = '0;                         // changed before E3
    step(); step();                          // E3, E4
    enable = 1'b0;                           // low from E5 onward
    edges = 4;
    for (int n = 5; n <= 40; n++) begin
      step();
      if (valid) begin edges = n; break; end
    end
    total++;
    if (edges != 16) begin bad++; $display("FAIL drop_latency: got %0d want 16", edges); end
    idx = first_bad_w();
    total++;
    if (idx != -1) begin bad++; $display("FAIL drop_w: coeff %0d got %0d want %0d", idx, w[idx*12 +: 12], exp_w[idx]); end
    step();
    total++;
    if (valid !== 1'b0 || debug_state !== 3'd0) begin
      bad++; $display("FAIL drop_leave_done: valid %b state %0d want 0 0", valid, debug_state);
    end
  endtask

`ifdef POLY_SUB_DECODE_EN
  task automatic test_decode();
    int edges;
    int tgt [4];
    tgt[0] = 832; tgt[1] = 833; tgt[2] = 2496; tgt[3] = 2497;
    for (int i = 0; i < N; i++) begin mv[i] = tgt[i % 4]; ms[i] = 0; end
    load_inputs();
    start_and_wait(edges);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(msg[k]) != ref_decode(tgt[k])) begin
        bad++; $display("FAIL decode_%0d: got %b want %0d", tgt[k], msg[k], ref_decode(tgt[k]));
      end
    end
    finish_run();
  endtask
`endif

  initial begin
    test_reset();
    test_const();
    test_boundary();
    test_mixed();
    test_random();
    test_reset_abort();
    test_enable_drop();
`ifdef POLY_SUB_DECODE_EN
    test_decode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
